stream_deserializer: RTL and testbench

Parametrised serial-to-parallel front end for the XOR cipher datapath. It accepts LANES bits per enabled beat, in MSB-first or LSB-first order, and assembles DATA_SIZE-bit words. Completed words go into a holding register with a valid/ready handshake, so the next word can shift in while the consumer (key/plaintext register, XOR core) drains the current one. A sticky overflow flag reports any word lost because the consumer was not ready.

---
 rtl/stream_deserializer.sv | 104 ++++++++++
 tb/tb_stream_deserializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stream_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_deserializer: LANES-bit serial beats to DATA_SIZE-bit words with a
// valid/ready holding register and sticky overflow.   Rev 1.0
// ---------------------------------------------------------------------------
module stream_deserializer #(
  parameter int DATA_SIZE = 32,
  parameter int LANES     = 1,
  parameter bit LSB_FIRST = 0
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iEn,
  input  logic                         iLoading,
  input  logic [LANES-1:0]             iData_in,
  input  logic                         iClear,
  input  logic                         iReady,
  output logic [DATA_SIZE-1:0]         oData,
  output logic                         oValid,
  output logic [$clog2(DATA_SIZE):0]   oBit_counter,
  output logic                         oOverflow
);

  localparam int CNT_W = $clog2(DATA_SIZE) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DATA_SIZE-1:0] sr;
  logic [DATA_SIZE-1:0] sr_next;
  logic [CNT_W-1:0]     count_sum;
  logic                 beat;
  logic                 complete;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign sr_next = {iData_in, sr[DATA_SIZE-1:LANES]};
    end else begin : g_msb_first
      assign sr_next = {sr[DATA_SIZE-LANES-1:0], iData_in};
    end
  endgenerate

  always_comb begin
    beat       = iEn & iLoading & ~iClear;
    count_sum  = oBit_counter + CNT_W'(LANES);
    complete   = beat && (count_sum == CNT_W'(DATA_SIZE));
    state_next = state;
    if (iClear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (beat) state_next = complete ? IDLE : SHIFT;
        SHIFT:   if (complete) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state        <= IDLE;
      sr           <= '0;
      oBit_counter <= '0;
    end else if (iClear) begin
      state        <= IDLE;
      sr           <= '0;
      oBit_counter <= '0;
    end else begin
      state <= state_next;
      if (beat) begin
        sr           <= sr_next;
        oBit_counter <= complete ? '0 : count_sum;
      end
    end
  end

  // A completed word is accepted only if the holding register is free or
  // being drained on the same edge; otherwise it is lost and flagged.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oData     <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      if (complete && (!oValid || iReady)) begin
        oData  <= sr_next;
        oValid <= 1'b1;
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end

      if (iClear)
        oOverflow <= 1'b0;
      else if (complete && oValid && !iReady)
        oOverflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_deserializer.sv
`default_nettype none
// Self-checking bench for stream_deserializer: three parameter sets with a
// scoreboard of expected words.
module tb_stream_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_c, loading, clear, ready;
  logic [0:0] d1;
  logic [1:0] d2;

  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       ovf_a, ovf_b, ovf_c;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stream_deserializer #(.DATA_SIZE(8), .LANES(1), .LSB_FIRST(0)) dut_a (
    .iClk(clk), .iRst(rst_n), .iEn(en_a), .iLoading(loading), .iData_in(d1),
    .iClear(clear), .iReady(ready), .oData(data_a), .oValid(valid_a),
    .oBit_counter(cnt_a), .oOverflow(ovf_a));

  stream_deserializer #(.DATA_SIZE(8), .LANES(1), .LSB_FIRST(1)) dut_b (
    .iClk(clk), .iRst(rst_n), .iEn(en_a), .iLoading(loading), .iData_in(d1),
    .iClear(clear), .iReady(ready), .oData(data_b), .oValid(valid_b),
    .oBit_counter(cnt_b), .oOverflow(ovf_b));

  stream_deserializer #(.DATA_SIZE(8), .LANES(2), .LSB_FIRST(0)) dut_c (
    .iClk(clk), .iRst(rst_n), .iEn(en_c), .iLoading(loading), .iData_in(d2),
    .iClear(clear), .iReady(ready), .oData(data_c), .oValid(valid_c),
    .oBit_counter(cnt_c), .oOverflow(ovf_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] w);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = w[7-j];
    return r;
  endfunction

  // Serial word into dut_a/dut_b, MSB of w first; iReady only on the last beat.
  task automatic send_a(input logic [7:0] w, input logic rdy_last, input logic accept);
    for (int i = 0; i < 8; i++) begin
      en_a  = 1'b1;
      d1    = w[7-i];
      ready = (i == 7) ? rdy_last : 1'b0;
      if (i == 7 && accept) begin
        qa.push_back(w);
        qb.push_back(bitrev(w));
      end
      tick();
      check("cnt_a", 32'(cnt_a), 32'((i + 1) % 8));
    end
    en_a  = 1'b0;
    ready = 1'b0;
    if (accept) begin
      check("data_a", 32'(data_a), 32'(qa.pop_front()));
      check("valid_a", 32'(valid_a), 32'd1);
      check("data_b", 32'(data_b), 32'(qb.pop_front()));
    end
  endtask

  initial begin
    logic [1:0] beats_c [4];
    beats_c = '{2'b10, 2'b11, 2'b00, 2'b01};
    rst_n = 1'b0; en_a = 0; en_c = 0; loading = 1; clear = 0; ready = 0;
    d1 = 0; d2 = 0;
    tick();
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // MSB-first B2 into dut_a, same stream LSB-first gives 4D in dut_b
    send_a(8'hB2, 1'b0, 1'b1);
    check("data_b_4d", 32'(data_b), 32'h4D);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("consume_a", 32'(valid_a), 32'd0);
    check("hold_a", 32'(data_a), 32'hB2);

    // Two-lane MSB-first
    for (int i = 0; i < 4; i++) begin
      en_c = 1'b1;
      d2   = beats_c[i];
      if (i == 3) qc.push_back(8'hB1);
      tick();
      check("cnt_c", 32'(cnt_c), 32'(((i + 1) * 2) % 8));
    end
    en_c = 1'b0;
    check("data_c", 32'(data_c), 32'(qc.pop_front()));
    check("valid_c", 32'(valid_c), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("consume_c", 32'(valid_c), 32'd0);
    check("hold_c", 32'(data_c), 32'hB1);

    // Overflow: second word dropped while first unconsumed
    send_a(8'hB2, 1'b0, 1'b1);
    send_a(8'h5A, 1'b0, 1'b0);
    check("ovf_data", 32'(data_a), 32'hB2);
    check("ovf_valid", 32'(valid_a), 32'd1);
    check("ovf_flag", 32'(ovf_a), 32'd1);
    check("ovf_flag_b", 32'(ovf_b), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ovf", 32'(ovf_a), 32'd0);
    check("clr_valid", 32'(valid_a), 32'd1);

    // Pause then abort
    for (int i = 0; i < 3; i++) begin
      en_a = 1'b1; d1 = 1'b1;
      tick();
    end
    loading = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en_a = i[0]; d1 = 1'b0;
      tick();
      check("pause_cnt", 32'(cnt_a), 32'd3);
    end
    en_a = 1'b0; loading = 1'b1;
    clear = 1'b1; en_a = 1'b1;
    tick();
    clear = 1'b0; en_a = 1'b0;
    check("abort_cnt", 32'(cnt_a), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    send_a(8'hFF, 1'b0, 1'b1);

    // Completion coinciding with consumption of the previous word
    send_a(8'hA5, 1'b1, 1'b1);
    check("cc_ovf", 32'(ovf_a), 32'd0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) begin
      en_a = 1'b1; d1 = 1'b1;
      tick();
    end
    en_a = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(data_a), 32'd0);
    check("arst_valid", 32'(valid_a), 32'd0);
    check("arst_cnt", 32'(cnt_a), 32'd0);
    check("arst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
